// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port-per-direction memory.
// Optionally zero-fills the memory after reset before serving requests.
module mem_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 64,
  parameter bit          CLEAR  = 1'b1,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [WIDTH-1:0]  a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  b_rdata,
  output logic              busy,
  output logic [WIDTH-1:0]  mem_data,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic              mem_rden,
  input  logic [WIDTH-1:0]  mem_q
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  // 0: A wins a tie, 1: B wins a tie (A was granted most recently).
  logic              ptr_q, ptr_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    ptr_d         = ptr_q;
    a_rvalid_d    = 1'b0;
    b_rvalid_d    = 1'b0;
    a_gnt         = 1'b0;
    b_gnt         = 1'b0;
    mem_data      = '0;
    mem_wraddress = '0;
    mem_wren      = 1'b0;
    mem_rdaddress = '0;
    mem_rden      = 1'b0;

    if (!reset) begin
      unique case (state_q)
        StClear: begin
          mem_wren      = 1'b1;
          mem_wraddress = clr_cnt_q;
          if (clr_cnt_q == LastAddr) begin
            clr_cnt_d = '0;
            state_d   = StRun;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (a_req && (!b_req || !ptr_q)) begin
            a_gnt = 1'b1;
          end else if (b_req) begin
            b_gnt = 1'b1;
          end

          if (a_gnt) begin
            ptr_d = 1'b1;
            if (a_we) begin
              mem_wren      = 1'b1;
              mem_wraddress = a_addr;
              mem_data      = a_wdata;
            end else begin
              mem_rden      = 1'b1;
              mem_rdaddress = a_addr;
              a_rvalid_d    = 1'b1;
            end
          end else if (b_gnt) begin
            ptr_d = 1'b0;
            if (b_we) begin
              mem_wren      = 1'b1;
              mem_wraddress = b_addr;
              mem_data      = b_wdata;
            end else begin
              mem_rden      = 1'b1;
              mem_rdaddress = b_addr;
              b_rvalid_d    = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CLEAR ? StClear : StRun;
      clr_cnt_q  <= '0;
      ptr_q      <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      ptr_q      <= ptr_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // Masking with reset cancels a read whose data would land in the reset cycle.
  assign a_rvalid = a_rvalid_q & ~reset;
  assign b_rvalid = b_rvalid_q & ~reset;
  assign a_rdata  = mem_q;
  assign b_rdata  = mem_q;
  assign busy     = reset | (state_q == StClear);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memories, directed stimulus and a read-data scoreboard.
module tb_mem_arbiter;

  localparam int W  = 8;
  localparam int D  = 64;
  localparam int AW = 6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, mem_init;
  int   n_checks = 0;
  int   n_errors = 0;

  // CLEAR=1 instance
  logic          a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
  logic [W-1:0]  a_rdata, b_rdata, mem_data, mem_q;
  logic [AW-1:0] mem_wraddress, mem_rdaddress;
  logic          mem_wren, mem_rden;

  // CLEAR=0 instance
  logic          a_req0, b_req0, a_we0, b_we0;
  logic [AW-1:0] a_addr0, b_addr0;
  logic [W-1:0]  a_wdata0, b_wdata0;
  logic          a_gnt0, b_gnt0, a_rvalid0, b_rvalid0, busy0;
  logic [W-1:0]  a_rdata0, b_rdata0, mem_data0, mem_q0;
  logic [AW-1:0] mem_wraddress0, mem_rdaddress0;
  logic          mem_wren0, mem_rden0;

  mem_arbiter #(.WIDTH(W), .DEPTH(D), .CLEAR(1'b1)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .busy(busy), .mem_data(mem_data), .mem_wraddress(mem_wraddress), .mem_wren(mem_wren),
    .mem_rdaddress(mem_rdaddress), .mem_rden(mem_rden), .mem_q(mem_q)
  );

  mem_arbiter #(.WIDTH(W), .DEPTH(D), .CLEAR(1'b0)) dut0 (
    .clock(clock), .reset(reset),
    .a_req(a_req0), .a_we(a_we0), .a_addr(a_addr0), .a_wdata(a_wdata0),
    .a_gnt(a_gnt0), .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
    .b_req(b_req0), .b_we(b_we0), .b_addr(b_addr0), .b_wdata(b_wdata0),
    .b_gnt(b_gnt0), .b_rvalid(b_rvalid0), .b_rdata(b_rdata0),
    .busy(busy0), .mem_data(mem_data0), .mem_wraddress(mem_wraddress0), .mem_wren(mem_wren0),
    .mem_rdaddress(mem_rdaddress0), .mem_rden(mem_rden0), .mem_q(mem_q0)
  );

  // Behavioural memories; mem1 starts non-zero so the clear sweep is observable.
  logic [W-1:0] mem1 [D];
  logic [W-1:0] mem0 [D];

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < D; i++) mem1[i] <= 8'hFF;
    end else begin
      if (mem_wren) mem1[mem_wraddress] <= mem_data;
      if (mem_rden) mem_q <= mem1[mem_rdaddress];
    end
  end

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < D; i++) mem0[i] <= W'(i) ^ 8'h5A;
    end else begin
      if (mem_wren0) mem0[mem_wraddress0] <= mem_data0;
      if (mem_rden0) mem_q0 <= mem0[mem_rdaddress0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for the CLEAR=1 instance: shadow memory plus per-port expected read data.
  logic [W-1:0] ref_mem [D];
  logic [W-1:0] a_exp_q [$];
  logic [W-1:0] b_exp_q [$];

  always @(negedge clock) begin
    if (reset) begin
      a_exp_q.delete();
      b_exp_q.delete();
      for (int i = 0; i < D; i++) ref_mem[i] = '0;
    end else begin
      if (a_rvalid) begin
        if (a_exp_q.size() == 0) check("a_rvalid_unexpected", 32'd1, 32'd0);
        else check("a_rdata", 32'(a_rdata), 32'(a_exp_q.pop_front()));
      end
      if (b_rvalid) begin
        if (b_exp_q.size() == 0) check("b_rvalid_unexpected", 32'd1, 32'd0);
        else check("b_rdata", 32'(b_rdata), 32'(b_exp_q.pop_front()));
      end
      if (a_req && a_gnt) begin
        if (a_we) ref_mem[a_addr] = a_wdata;
        else a_exp_q.push_back(ref_mem[a_addr]);
      end
      if (b_req && b_gnt) begin
        if (b_we) ref_mem[b_addr] = b_wdata;
        else b_exp_q.push_back(ref_mem[b_addr]);
      end
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic check_clear_sweep(input int first);
    for (int i = first; i < D; i++) begin
      @(negedge clock);
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_wren", 32'(mem_wren), 32'd1);
      check("clr_addr", 32'(mem_wraddress), 32'(i));
      check("clr_data", 32'(mem_data), 32'd0);
      check("clr_rden", 32'(mem_rden), 32'd0);
      next();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_addr = '0; b_addr = '0;
    a_wdata = '0; b_wdata = '0;
    a_req0 = 0; b_req0 = 0; a_we0 = 0; b_we0 = 0; a_addr0 = '0; b_addr0 = '0;
    a_wdata0 = '0; b_wdata0 = '0;
    next();
    mem_init = 1'b0;
    // Requests during reset must be ignored.
    a_req = 1; a_we = 0; a_addr = 6'd0;
    a_req0 = 1; a_we0 = 0; a_addr0 = 6'd9;
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_a_gnt", 32'(a_gnt), 32'd0);
    check("rst_wren", 32'(mem_wren), 32'd0);
    check("rst_rden", 32'(mem_rden), 32'd0);
    check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd1);
    check("rst_a_gnt0", 32'(a_gnt0), 32'd0);
    next();
    reset = 1'b0;

    // Clear sweep on dut; dut0 (no clear) serves immediately.
    for (int i = 0; i < D; i++) begin
      @(negedge clock);
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_wren", 32'(mem_wren), 32'd1);
      check("clr_addr", 32'(mem_wraddress), 32'(i));
      check("clr_data", 32'(mem_data), 32'd0);
      check("clr_a_gnt", 32'(a_gnt), 32'd0);
      check("clr_rden", 32'(mem_rden), 32'd0);
      if (i == 0) begin
        check("nc_busy0", 32'(busy0), 32'd0);
        check("nc_a_gnt0", 32'(a_gnt0), 32'd1);
        check("nc_wren0", 32'(mem_wren0), 32'd0);
        check("nc_rden0", 32'(mem_rden0), 32'd1);
        check("nc_rdaddr0", 32'(mem_rdaddress0), 32'd9);
      end
      if (i == 1) begin
        check("nc_a_rvalid0", 32'(a_rvalid0), 32'd1);
        check("nc_a_rdata0", 32'(a_rdata0), 32'h53);
        check("nc_b_rvalid0", 32'(b_rvalid0), 32'd0);
        check("nc_wren0_idle", 32'(mem_wren0), 32'd0);
      end
      next();
      if (i == 0) a_req0 = 0;
    end

    // First RUN cycle: held request granted without delay.
    @(negedge clock);
    check("run_busy", 32'(busy), 32'd0);
    check("run_a_gnt", 32'(a_gnt), 32'd1);
    check("run_rden", 32'(mem_rden), 32'd1);
    check("run_wren", 32'(mem_wren), 32'd0);
    next();
    a_req = 0;
    @(negedge clock);
    check("run_a_rvalid", 32'(a_rvalid), 32'd1);
    next();

    // A writes 0xA5 to 5, B reads 5 the next cycle.
    a_req = 1; a_we = 1; a_addr = 6'd5; a_wdata = 8'hA5;
    @(negedge clock);
    check("wr_a_gnt", 32'(a_gnt), 32'd1);
    check("wr_b_gnt", 32'(b_gnt), 32'd0);
    check("wr_wren", 32'(mem_wren), 32'd1);
    check("wr_addr", 32'(mem_wraddress), 32'd5);
    check("wr_data", 32'(mem_data), 32'hA5);
    check("wr_rden", 32'(mem_rden), 32'd0);
    next();
    a_req = 0; b_req = 1; b_we = 0; b_addr = 6'd5;
    @(negedge clock);
    check("raw_b_gnt", 32'(b_gnt), 32'd1);
    check("raw_rden", 32'(mem_rden), 32'd1);
    check("raw_rdaddr", 32'(mem_rdaddress), 32'd5);
    check("raw_wren", 32'(mem_wren), 32'd0);
    check("raw_a_rvalid", 32'(a_rvalid), 32'd0);
    next();
    b_req = 0;
    @(negedge clock);
    check("raw_b_rvalid", 32'(b_rvalid), 32'd1);
    check("raw_b_rdata", 32'(b_rdata), 32'hA5);
    check("raw_a_rvalid2", 32'(a_rvalid), 32'd0);
    next();

    // B writes 0x3C to 7; B was last granted so A now wins ties.
    b_req = 1; b_we = 1; b_addr = 6'd7; b_wdata = 8'h3C;
    @(negedge clock);
    check("wr7_b_gnt", 32'(b_gnt), 32'd1);
    next();
    b_req = 0;

    // Both reading continuously: A,B,A,B.
    a_req = 1; a_we = 0; a_addr = 6'd5;
    b_req = 1; b_we = 0; b_addr = 6'd7;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("rr_a_gnt", 32'(a_gnt), 32'((k % 2) == 0));
      check("rr_b_gnt", 32'(b_gnt), 32'((k % 2) == 1));
      check("rr_rden", 32'(mem_rden), 32'd1);
      check("rr_wren", 32'(mem_wren), 32'd0);
      if (k > 0) begin
        check("rr_a_rvalid", 32'(a_rvalid), 32'((k % 2) == 1));
        check("rr_b_rvalid", 32'(b_rvalid), 32'((k % 2) == 0));
      end
      next();
    end
    a_req = 0; b_req = 0;
    @(negedge clock);
    check("rr_b_rvalid_last", 32'(b_rvalid), 32'd1);
    check("rr_a_rvalid_last", 32'(a_rvalid), 32'd0);
    next();

    // B alone for 3 cycles, then a tie goes to A.
    b_req = 1; b_we = 0; b_addr = 6'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("solo_b_gnt", 32'(b_gnt), 32'd1);
      check("solo_a_gnt", 32'(a_gnt), 32'd0);
      next();
    end
    a_req = 1; a_we = 0; a_addr = 6'd5;
    @(negedge clock);
    check("tie_a_gnt", 32'(a_gnt), 32'd1);
    check("tie_b_gnt", 32'(b_gnt), 32'd0);
    next();
    a_req = 0;
    @(negedge clock);
    check("tie_b_gnt_after", 32'(b_gnt), 32'd1);
    next();
    b_req = 0;
    @(negedge clock);
    next();

    // Reset the cycle after a read grant: no rvalid, clear restarts at 0.
    a_req = 1; a_we = 0; a_addr = 6'd5;
    @(negedge clock);
    check("rr_pre_a_gnt", 32'(a_gnt), 32'd1);
    next();
    a_req = 0; reset = 1;
    @(negedge clock);
    check("rst2_a_rvalid", 32'(a_rvalid), 32'd0);
    check("rst2_busy", 32'(busy), 32'd1);
    check("rst2_wren", 32'(mem_wren), 32'd0);
    next();
    reset = 0;
    @(negedge clock);
    check("rst2_a_rvalid_after", 32'(a_rvalid), 32'd0);
    next();
    // Interrupt the sweep at address 10 and confirm it restarts.
    for (int i = 1; i < 10; i++) begin
      @(negedge clock);
      check("part_addr", 32'(mem_wraddress), 32'(i));
      next();
    end
    reset = 1;
    next();
    reset = 0;
    check_clear_sweep(0);
    @(negedge clock);
    check("rerun_busy", 32'(busy), 32'd0);
    next();

    // Previously written data must be gone after the clear.
    a_req = 1; a_we = 0; a_addr = 6'd5;
    @(negedge clock);
    check("post_a_gnt", 32'(a_gnt), 32'd1);
    next();
    a_req = 0;
    @(negedge clock);
    check("post_a_rvalid", 32'(a_rvalid), 32'd1);
    check("post_a_rdata", 32'(a_rdata), 32'd0);
    next();
    @(negedge clock);
    check("a_queue_empty", 32'(a_exp_q.size()), 32'd0);
    check("b_queue_empty", 32'(b_exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter DEPTH, default 64, word count of the attached memory; ADDR_W = ceil(log2(DEPTH)).
REQ-003 SHALL have parameter CLEAR, default 1; when 1, the memory is zero-filled after reset.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have ports a_req / b_req, input, 1, access request from requester A / B.
REQ-007 SHALL have ports a_we / b_we, input, 1; 1 = write, 0 = read.
REQ-008 SHALL have ports a_addr / b_addr, input, ADDR_W, word address.
REQ-009 SHALL have ports a_wdata / b_wdata, input, WIDTH, write data.
REQ-010 SHALL have ports a_gnt / b_gnt, output, 1; the request is accepted this cycle.
REQ-011 SHALL have ports a_rvalid / b_rvalid, output, 1; read data is valid this cycle.
REQ-012 SHALL have ports a_rdata / b_rdata, output, WIDTH, both driven from mem_q.
REQ-013 SHALL have port busy, output, 1; high while in reset or in the CLEAR state.
REQ-014 SHALL have ports mem_data (WIDTH), mem_wraddress (ADDR_W) and mem_wren (1), outputs forming the memory write port.
REQ-015 SHALL have ports mem_rdaddress (ADDR_W) and mem_rden (1), outputs forming the memory read port.
REQ-016 SHALL have port mem_q, input, WIDTH, memory read data, registered with 1-cycle latency after mem_rden.

Function
REQ-017 SHALL implement FSM states CLEAR and RUN.
- reset -> CLEAR if CLEAR=1, else RUN.
REQ-018 In CLEAR, SHALL write one word per cycle: mem_wren=1, mem_data=0, mem_wraddress=clr_cnt.
- clr_cnt increments 0..DEPTH-1.
- After the write of DEPTH-1, the state becomes RUN, so CLEAR lasts exactly DEPTH cycles.
REQ-019 In CLEAR and during reset, SHALL hold a_gnt=b_gnt=0 and mem_rden=0; requests are ignored and not queued.
REQ-020 In RUN, gnt SHALL be combinational from req and the priority pointer, at most one per cycle.
- A transfer occurs in any cycle where req and gnt are both high.
REQ-021 Arbitration in RUN SHALL work as follows:
- Only one requester active: that requester is granted with no bubble.
- Both active: the requester not granted most recently wins.
- The pointer updates on every grant.
- After reset the pointer favours A.
REQ-022 On a granted write, SHALL drive mem_wren=1 and set mem_wraddress and mem_data from the granted port in the same cycle.
REQ-023 On a granted read, SHALL drive mem_rden=1 and mem_rdaddress=addr in the same cycle.
- Exactly one cycle later, SHALL assert rvalid for 1 cycle on the granting port only.
REQ-024 SHALL never assert mem_rden and mem_wren in the same cycle.
REQ-025 When a memory port is unused, SHALL drive its enable, address and data outputs to 0.
REQ-026 Requesters SHALL hold req, we, addr and wdata stable until granted; the arbiter does not register them.
REQ-027 Back-to-back read after write to the same address (write in cycle N, read granted in N+1) SHALL return the new data in N+2.
REQ-028 Sustained throughput SHALL be one access per cycle in RUN; rvalid for consecutive reads may be high on successive cycles, alternating between ports.

Reset
REQ-029 Reset SHALL produce the following:
- gnt=0, rvalid=0, mem_wren=0, mem_rden=0 and busy=1.
- clr_cnt=0 and pointer favouring A.
- Any pending rvalid is cancelled.
- A CLEAR sweep in progress restarts from address 0.

Verification
REQ-030 SHALL cover CLEAR=1, DEPTH=64, reset released:
- busy=1 for exactly 64 cycles, with mem_wren=1 and addresses 0..63 with data 0 in order.
- Then busy=0, and a request is granted in the first RUN cycle.
REQ-031 SHALL cover A writing 0xA5 to addr 5, then B reading addr 5 next cycle:
- b_rvalid=1 one cycle after b_gnt, with b_rdata=0xA5.
- a_rvalid stays 0.
REQ-032 SHALL cover both ports holding read requests continuously: grants go A,B,A,B.
- rvalid follows each grant by 1 cycle on the matching port.
- mem_rden stays 1 every cycle.
REQ-033 SHALL cover only B requesting for 3 cycles, then both requesting: B is granted on 3 consecutive cycles, then A wins the tie.
REQ-034 SHALL cover reset asserted the cycle after a read grant:
- No rvalid appears.
- busy=1 and the clear restarts at address 0.
REQ-035 SHALL cover CLEAR=0, reset released: busy=0 immediately, with no clear writes and requests granted in the first cycle.
